// File: rtl/punch_hit_gen.sv
// Punch swing sequencer: windup/active/recover phases, reach test,
// one-hit-per-swing damage to the opponent's health, KO lockout.
//
// Ports:
//   clk          frame clock (one cycle = one game frame)
//   Reset        asynchronous active-high reset
//   PunchKey     attacker punch key level; a rising edge in IDLE starts a swing
//   Facing       1 = attacker faces +X, 0 = attacker faces -X
//   Xpos_self    attacker X position (signed 32-bit)
//   Xpos_opp     opponent X position (signed 32-bit)
//   Opp_Busy     opponent in knockback; blocks any hit
//   Punch        registered one-cycle hit pulse
//   Arm_State    00 idle, 01 windup, 10 active, 11 recover
//   Busy         high whenever a swing is in progress
//   Opp_Health   opponent health, saturating at 0
//   KO           high while Opp_Health is 0

module punch_hit_gen #(
  parameter int WINDUP_LEN  = 3,
  parameter int ACTIVE_LEN  = 2,
  parameter int RECOVER_LEN = 4,
  parameter int REACH       = 40,
  parameter int DAMAGE      = 10,
  parameter int MAX_HEALTH  = 100
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               PunchKey,
  input  logic               Facing,
  input  logic signed [31:0] Xpos_self,
  input  logic signed [31:0] Xpos_opp,
  input  logic               Opp_Busy,
  output logic               Punch,
  output logic [1:0]         Arm_State,
  output logic               Busy,
  output logic [7:0]         Opp_Health,
  output logic               KO
);

  localparam int MAXLEN_WA =
    (WINDUP_LEN > ACTIVE_LEN) ? WINDUP_LEN : ACTIVE_LEN;
  localparam int MAXLEN =
    (MAXLEN_WA > RECOVER_LEN) ? MAXLEN_WA : RECOVER_LEN;
  localparam int CW = (MAXLEN < 2) ? 1 : $clog2(MAXLEN);

  localparam logic [CW-1:0] W_LAST = CW'(WINDUP_LEN - 1);
  localparam logic [CW-1:0] A_LAST = CW'(ACTIVE_LEN - 1);
  localparam logic [CW-1:0] R_LAST = CW'(RECOVER_LEN - 1);

  localparam logic [7:0] MAX8 = 8'(MAX_HEALTH);
  localparam logic [7:0] DMG8 = 8'(DAMAGE);

  localparam logic signed [31:0] REACH_S = 32'(REACH);

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_WINDUP  = 2'b01;
  localparam logic [1:0] S_ACTIVE  = 2'b10;
  localparam logic [1:0] S_RECOVER = 2'b11;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_nxt;
  logic               r_key_q;
  logic               r_hit_done;
  logic               r_punch;
  logic [7:0]         r_health;
  logic               w_ko;
  logic               w_start;
  logic signed [31:0] w_d;
  logic               w_in_reach;
  logic               w_hit;
  logic [7:0]         w_health_hit;

  assign w_ko = (r_health == 8'd0);

  // Edge detect against the previous key sample; a key held
  // through a swing never re-triggers because edges are only
  // honoured in IDLE.
  assign w_start = (r_state == S_IDLE) && PunchKey &&
                   !r_key_q && !w_ko;

  assign w_d = Facing ? (Xpos_opp - Xpos_self)
                      : (Xpos_self - Xpos_opp);

  assign w_in_reach = (w_d >= 32'sd0) && (w_d <= REACH_S);

  // KO also gates the hit so a swing started before the KO
  // finishes harmlessly.
  assign w_hit = (r_state == S_ACTIVE) && w_in_reach &&
                 !Opp_Busy && !r_hit_done && !w_ko;

  assign w_health_hit = (r_health < DMG8) ? 8'd0
                                          : (r_health - DMG8);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_start) begin
          w_state_nxt = S_WINDUP;
        end
      end
      S_WINDUP: begin
        if (r_cnt == W_LAST) begin
          w_state_nxt = S_ACTIVE;
          w_cnt_nxt   = '0;
        end
      end
      S_ACTIVE: begin
        if (r_cnt == A_LAST) begin
          w_state_nxt = S_RECOVER;
          w_cnt_nxt   = '0;
        end
      end
      S_RECOVER: begin
        if (r_cnt == R_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Previous-key sample resets high so a key held across reset
  // release does not look like a fresh press.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_key_q <= 1'b1;
    end else begin
      r_key_q <= PunchKey;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_hit_done <= 1'b0;
    end else if (w_start) begin
      r_hit_done <= 1'b0;
    end else if (w_hit) begin
      r_hit_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_punch  <= 1'b0;
      r_health <= MAX8;
    end else begin
      r_punch <= w_hit;
      if (w_hit) begin
        r_health <= w_health_hit;
      end
    end
  end

  always_comb begin
    Arm_State = 2'b00;
    Busy      = 1'b0;
    case (r_state)
      S_WINDUP: begin
        Arm_State = 2'b01;
        Busy      = 1'b1;
      end
      S_ACTIVE: begin
        Arm_State = 2'b10;
        Busy      = 1'b1;
      end
      S_RECOVER: begin
        Arm_State = 2'b11;
        Busy      = 1'b1;
      end
      default: begin
        Arm_State = 2'b00;
        Busy      = 1'b0;
      end
    endcase
  end

  assign Punch      = r_punch;
  assign Opp_Health = r_health;
  assign KO         = w_ko;

endmodule

// File: tb/tb_punch_hit_gen.sv
// Scoreboard bench for punch_hit_gen: two instances (DAMAGE 10 and 30)
// share stimulus; a swing-timeline model predicts every frame.

module tb_punch_hit_gen;

  localparam int WL   = 3;
  localparam int AL   = 2;
  localparam int RL   = 4;
  localparam int SLEN = WL + AL + RL;
  localparam int RCH  = 40;
  localparam int MAXH = 100;

  typedef struct packed {
    logic       punch;
    logic [1:0] arm;
    logic       busy;
    logic [7:0] hp;
    logic       ko;
  } exp_t;

  typedef struct packed {
    exp_t a;
    exp_t b;
  } pair_t;

  logic               clk;
  logic               Reset;
  logic               PunchKey;
  logic               Facing;
  logic signed [31:0] Xpos_self;
  logic signed [31:0] Xpos_opp;
  logic               Opp_Busy;

  logic       p0, p1, b0, b1, k0, k1;
  logic [1:0] a0, a1;
  logic [7:0] h0, h1;

  punch_hit_gen #(
    .WINDUP_LEN(WL), .ACTIVE_LEN(AL), .RECOVER_LEN(RL),
    .REACH(RCH), .DAMAGE(10), .MAX_HEALTH(MAXH)
  ) u_dut10 (
    .clk(clk), .Reset(Reset), .PunchKey(PunchKey),
    .Facing(Facing), .Xpos_self(Xpos_self),
    .Xpos_opp(Xpos_opp), .Opp_Busy(Opp_Busy),
    .Punch(p0), .Arm_State(a0), .Busy(b0),
    .Opp_Health(h0), .KO(k0)
  );

  punch_hit_gen #(
    .WINDUP_LEN(WL), .ACTIVE_LEN(AL), .RECOVER_LEN(RL),
    .REACH(RCH), .DAMAGE(30), .MAX_HEALTH(MAXH)
  ) u_dut30 (
    .clk(clk), .Reset(Reset), .PunchKey(PunchKey),
    .Facing(Facing), .Xpos_self(Xpos_self),
    .Xpos_opp(Xpos_opp), .Opp_Busy(Opp_Busy),
    .Punch(p1), .Arm_State(a1), .Busy(b1),
    .Opp_Health(h1), .KO(k1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  pair_t q[$];
  int    hp30_log[$];
  bit    log_en = 1'b0;
  int    cyc = 0;

  // Model: elapsed frames since swing start (-1 = idle).
  int m_e[2];
  int m_hp[2];
  bit m_hit[2];
  bit m_prev[2];
  bit m_punch[2];
  int m_dmg[2] = '{10, 30};

  function automatic exp_t m_out(input int k);
    exp_t r;
    r.punch = m_punch[k];
    r.busy  = (m_e[k] >= 0);
    if (m_e[k] < 0)            r.arm = 2'd0;
    else if (m_e[k] < WL)      r.arm = 2'd1;
    else if (m_e[k] < WL + AL) r.arm = 2'd2;
    else                       r.arm = 2'd3;
    r.hp = 8'(m_hp[k]);
    r.ko = (m_hp[k] == 0);
    return r;
  endfunction

  task automatic model_step();
    int d;
    bit act, p;
    for (int k = 0; k < 2; k++) begin
      if (Reset) begin
        m_e[k] = -1; m_hp[k] = MAXH; m_hit[k] = 0;
        m_prev[k] = 1; m_punch[k] = 0;
      end else begin
        d = Facing ? (int'(Xpos_opp) - int'(Xpos_self))
                   : (int'(Xpos_self) - int'(Xpos_opp));
        act = (m_e[k] >= WL) && (m_e[k] < WL + AL);
        p = act && d >= 0 && d <= RCH && !Opp_Busy &&
            !m_hit[k] && m_hp[k] > 0;
        if (p) begin
          m_hp[k] = (m_hp[k] < m_dmg[k]) ? 0
                                         : m_hp[k] - m_dmg[k];
          m_hit[k] = 1;
        end
        if (m_e[k] >= 0) begin
          m_e[k] = m_e[k] + 1;
          if (m_e[k] == SLEN) m_e[k] = -1;
        end else if (PunchKey && !m_prev[k] && m_hp[k] > 0) begin
          m_e[k] = 0;
          m_hit[k] = 0;
        end
        m_prev[k] = PunchKey;
        m_punch[k] = p;
      end
    end
  endtask

  task automatic cmp(input string nm, input exp_t w, input exp_t g);
    checks++;
    if (g !== w) begin
      errors++;
      $display("FAIL %s cyc=%0d got p=%b arm=%0d busy=%b hp=%0d ko=%b want p=%b arm=%0d busy=%b hp=%0d ko=%b",
               nm, cyc, g.punch, g.arm, g.busy, g.hp, g.ko,
               w.punch, w.arm, w.busy, w.hp, w.ko);
    end
  endtask

  task automatic chk_int(input string nm, input int g, input int w);
    checks++;
    if (g != w) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, g, w);
    end
  endtask

  // Monitor: one expected pair per clock edge, popped and compared.
  always @(posedge clk) begin
    pair_t e;
    #1;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("dut10", e.a, {p0, a0, b0, h0, k0});
      cmp("dut30", e.b, {p1, a1, b1, h1, k1});
    end
    if (log_en && p1) hp30_log.push_back(int'(h1));
  end

  task automatic step(input bit key, input bit fac,
                      input int s, input int o,
                      input bit busy, input bit rst);
    pair_t e;
    @(negedge clk);
    Reset = rst; PunchKey = key; Facing = fac;
    Xpos_self = s; Xpos_opp = o; Opp_Busy = busy;
    model_step();
    e.a = m_out(0);
    e.b = m_out(1);
    q.push_back(e);
  endtask

  task automatic swing(input bit fac, input int s, input int o,
                       input int busy_at, input int hold,
                       input int n);
    for (int i = 0; i < n; i++)
      step(i < hold, fac, s, o, i == busy_at, 1'b0);
  endtask

  initial begin
    exp_t rst_exp;
    rst_exp = {1'b0, 2'b00, 1'b0, 8'd100, 1'b0};
    Reset = 1'b1; PunchKey = 1'b0; Facing = 1'b1;
    Xpos_self = 0; Xpos_opp = 0; Opp_Busy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_e[k] = -1; m_hp[k] = MAXH; m_hit[k] = 0;
      m_prev[k] = 1; m_punch[k] = 0;
    end
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0);

    log_en = 1'b1;
    swing(1, 100, 130, -1, 2, 11);
    swing(1, 100, 140, -1, 1, 11);
    swing(1, 100, 141, -1, 1, 11);
    swing(0, 100, 130, -1, 1, 11);
    swing(1, 100, 130, -1, 1, 11);
    swing(1, 100, 130, 4, 1, 11);
    swing(1, 100, 100, -1, 1, 11);
    swing(1, 130, 100, -1, 1, 11);
    swing(1, 100, 120, -1, 15, 20);
    log_en = 1'b0;
    @(negedge clk);
    chk_int("hp30_log_len", hp30_log.size(), 4);
    if (hp30_log.size() == 4) begin
      chk_int("hp30_1", hp30_log[0], 70);
      chk_int("hp30_2", hp30_log[1], 40);
      chk_int("hp30_3", hp30_log[2], 10);
      chk_int("hp30_4", hp30_log[3], 0);
    end
    chk_int("hp10_after_directed", int'(h0), 40);

    // Reset pulse in the first ACTIVE frame, key held throughout.
    for (int i = 0; i < 4; i++) step(1, 1, 100, 130, 0, 0);
    step(1, 1, 100, 130, 0, 1);
    #1;
    cmp("async_rst10", rst_exp, {p0, a0, b0, h0, k0});
    cmp("async_rst30", rst_exp, {p1, a1, b1, h1, k1});
    step(1, 1, 100, 130, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 100, 130, 0, 0);
    chk_int("held_no_swing", int'(b0), 0);
    step(0, 1, 100, 130, 0, 0);

    for (int n = 0; n < 10; n++) swing(1, 100, 125, -1, 1, 10);
    step(0, 1, 100, 125, 0, 0);
    chk_int("ko10_flag", int'(k0), 1);
    chk_int("ko10_hp", int'(h0), 0);
    step(1, 1, 100, 125, 0, 0);
    step(0, 1, 100, 125, 0, 0);
    chk_int("ko_refuse_idle", int'(a0), 0);

    step(0, 1, 100, 125, 0, 1);
    for (int i = 0; i < 400; i++) begin
      int s, o;
      s = 100 + int'($urandom_range(0, 20));
      o = s + int'($urandom_range(0, 100)) - 50;
      step($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
           s, o, $urandom_range(0, 4) == 0,
           $urandom_range(0, 79) == 0);
    end

    repeat (3) @(negedge clk);
    chk_int("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/punch_hit_gen.md
PUNCH_HIT_GEN -- requirements
Module: punch_hit_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- WINDUP_LEN, 3, cycles in WINDUP
- ACTIVE_LEN, 2, cycles in ACTIVE (hit window)
- RECOVER_LEN, 4, cycles in RECOVER
- REACH, 40, max hit distance in pixels, inclusive
- DAMAGE, 10, health removed per landed hit
- MAX_HEALTH, 100, opponent health after reset
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk  in  1  single clock; one cycle = one game frame
- Reset  in  1  asynchronous, active-high reset
- PunchKey  in  1  attacker punch key level
- Facing  in  1  1 = attacker faces +X, 0 = attacker faces -X
- Xpos_self  in  32 signed (int)  attacker X position
- Xpos_opp  in  32 signed (int)  opponent X position
- Opp_Busy  in  1  opponent knockback in progress; no hit may land
- Punch  out  1  one-cycle hit pulse to the opponent's knockback controller
- Arm_State  out  2  00 idle, 01 windup, 10 active, 11 recover (sprite select)
- Busy  out  1  high in any state other than IDLE
- Opp_Health  out  8  opponent health, saturating at 0
- KO  out  1  high while Opp_Health == 0

Function
REQ-003 States: IDLE, WINDUP, ACTIVE, RECOVER; a phase counter tracks cycles spent in the current state.
REQ-004 Swing trigger: a rising edge of PunchKey (PunchKey=1, previous sample=0) seen in IDLE with KO=0 moves the FSM to WINDUP on that clock edge, with the counter at 0.
REQ-005 A held key shall start exactly one swing; PunchKey edges outside IDLE are ignored and not buffered.
REQ-006 WINDUP -> ACTIVE after WINDUP_LEN cycles; ACTIVE -> RECOVER after ACTIVE_LEN cycles; RECOVER -> IDLE after RECOVER_LEN cycles. A full swing therefore occupies WINDUP_LEN+ACTIVE_LEN+RECOVER_LEN cycles.
REQ-007 Distance d: d = Xpos_opp - Xpos_self when Facing=1, else Xpos_self - Xpos_opp; 32-bit signed arithmetic.
REQ-008 Hit condition, evaluated in ACTIVE only: 0 <= d <= REACH, Opp_Busy=0, and no hit has yet landed in this swing.
REQ-009 Punch is registered: high for exactly one cycle, the cycle after the first ACTIVE cycle in which the hit condition holds; at most one Punch per swing.
REQ-010 On the edge that sets Punch, Opp_Health <= Opp_Health - DAMAGE, clamped to 0 if Opp_Health < DAMAGE.
REQ-011 Boundaries: d = REACH hits; d = REACH+1 misses; d = 0 (overlap) hits; opponent behind the attacker (d < 0) misses.
REQ-012 Once KO=1, new swings are refused; a swing already in progress completes but cannot land a hit.
REQ-013 Arm_State and Busy are decoded combinationally from the current state.

Reset
REQ-014 Reset=1 asynchronously forces: state IDLE, counter 0, Punch 0, Opp_Health MAX_HEALTH, KO 0, per-swing hit flag 0.
REQ-015 The previous-key register resets to 1, so a key held through reset release shall not start a swing.
REQ-016 Reset asserted mid-swing aborts the swing immediately; Punch shall not be asserted on the cycle after reset deasserts.

Verification
REQ-017 Directed scenarios a bench must cover:
- Key rises at cycle 0 in IDLE, Facing=1, self=100, opp=130 -> WINDUP cycles 1-3, ACTIVE 4-5, Punch=1 at cycle 5 only, Opp_Health 100->90, IDLE at cycle 10.
- opp=140 (d=40) -> hit lands; opp=141 (d=41) -> no Punch and health unchanged, swing still takes 9 cycles.
- Facing=0, self=100, opp=130 -> no hit; the same positions with Facing=1 -> hit.
- Opp_Busy=1 in the first ACTIVE cycle and 0 in the second -> Punch pulses once, the cycle after the second ACTIVE cycle.
- Ten landed hits with DAMAGE=10 -> Opp_Health=0, KO=1, and the next key edge leaves the FSM in IDLE; with DAMAGE=30 the health sequence is 70, 40, 10, 0 (clamped).
- Reset pulsed during ACTIVE -> all outputs at reset values immediately; key still held after release -> no new swing until the key is released and pressed again.
